// File: rtl/tpu_pkg.sv
// Shared TPU datapath types and constants: accumulator/activation widths,
// the requantizer configuration record and the int8 activation range.
package tpu_pkg;

    localparam int ACC_W       = 32;
    localparam int ACT_W       = 8;
    localparam int REQ_SHIFT_W = 6;

    localparam logic signed [ACT_W-1:0] ACT_MAX = 8'sh7f;
    localparam logic signed [ACT_W-1:0] ACT_MIN = 8'sh80;

    typedef struct packed {
        logic signed [ACC_W-1:0]  scale;
        logic [REQ_SHIFT_W-1:0]   shift;
        logic signed [ACT_W-1:0]  zp;
    } req_cfg_t;

    // Identity transform: scale by one, no shift, no offset.
    localparam req_cfg_t REQ_CFG_RST = '{
        scale: 32'sd1,
        shift: '0,
        zp:    '0
    };

endpackage

// File: rtl/requant_if.sv
// Requantizer bus: config load strobe and valid-only activation stream.
// master drives cfg/data inputs and observes outputs; slave is the block.
interface requant_if #(
    parameter int IN_W    = 32,
    parameter int SCALE_W = 32,
    parameter int SHIFT_W = 6,
    parameter int OUT_W   = 8
);

    logic               cfg_valid_i;
    logic [SCALE_W-1:0] cfg_scale_i;
    logic [SHIFT_W-1:0] cfg_shift_i;
    logic [OUT_W-1:0]   cfg_zp_i;
    logic               data_valid_i;
    logic [IN_W-1:0]    data_i;
    logic               data_valid_o;
    logic [OUT_W-1:0]   data_o;

    modport master (
        output cfg_valid_i, cfg_scale_i, cfg_shift_i, cfg_zp_i,
        output data_valid_i, data_i,
        input  data_valid_o, data_o
    );

    modport slave (
        input  cfg_valid_i, cfg_scale_i, cfg_shift_i, cfg_zp_i,
        input  data_valid_i, data_i,
        output data_valid_o, data_o
    );

endinterface

// File: rtl/requant_sat_clamp.sv
// Combinational signed saturation of an IN_W value to OUT_W bits.
// Ports: x_i (signed IN_W input), y_o (signed OUT_W clamped result).
module sat_clamp #(
    parameter int IN_W  = 66,
    parameter int OUT_W = 8
) (
    input  logic signed [IN_W-1:0]  x_i,
    output logic [OUT_W-1:0]        y_o
);

    localparam logic signed [IN_W-1:0] MAXV = IN_W'((1 << (OUT_W - 1)) - 1);
    localparam logic signed [IN_W-1:0] MINV = -MAXV - IN_W'(1);

    always_comb begin
        y_o = x_i[OUT_W-1:0];
        if (x_i > MAXV) begin
            y_o = MAXV[OUT_W-1:0];
        end else if (x_i < MINV) begin
            y_o = MINV[OUT_W-1:0];
        end
    end

endmodule

// File: rtl/requant.sv
// Requantizer: int32 activations -> int8 via scale, rounding shift,
// zero-point add and saturation in a 3-stage valid-only pipeline.
// Ports: clk_i, rst_i (async, active-high), bus (requant_if.slave).
module requant
    import tpu_pkg::*;
#(
    parameter int IN_W    = ACC_W,
    parameter int SCALE_W = ACC_W,
    parameter int SHIFT_W = REQ_SHIFT_W,
    parameter int OUT_W   = ACT_W
) (
    input  logic      clk_i,
    input  logic      rst_i,
    requant_if.slave  bus
);

    localparam int PROD_W = IN_W + SCALE_W;
    // One extra bit so the rounding increment cannot overflow.
    localparam int RND_W  = PROD_W + 1;
    localparam int SUM_W  = RND_W + 1;

    req_cfg_t cfg_q, cfg_d;

    logic                      s1_vld_q, s1_vld_d;
    logic signed [PROD_W-1:0]  s1_prod_q, s1_prod_d;
    logic [SHIFT_W-1:0]        s1_shift_q, s1_shift_d;
    logic signed [OUT_W-1:0]   s1_zp_q, s1_zp_d;

    logic                      s2_vld_q, s2_vld_d;
    logic signed [RND_W-1:0]   s2_r_q, s2_r_d;
    logic signed [OUT_W-1:0]   s2_zp_q, s2_zp_d;

    logic                      out_vld_q, out_vld_d;
    logic [OUT_W-1:0]          out_q, out_d;

    logic signed [RND_W-1:0]   prod_x;
    logic signed [RND_W-1:0]   rnd;
    logic signed [SUM_W-1:0]   sum;
    logic [OUT_W-1:0]          sat;

    // Stage 1 reads cfg_q, so a beat arriving with the load strobe
    // still sees the previous configuration.
    always_comb begin
        cfg_d = cfg_q;
        if (bus.cfg_valid_i) begin
            cfg_d.scale = $signed(bus.cfg_scale_i);
            cfg_d.shift = bus.cfg_shift_i;
            cfg_d.zp    = $signed(bus.cfg_zp_i);
        end
    end

    always_comb begin
        s1_vld_d   = bus.data_valid_i;
        s1_prod_d  = s1_prod_q;
        s1_shift_d = s1_shift_q;
        s1_zp_d    = s1_zp_q;
        if (bus.data_valid_i) begin
            s1_prod_d  = PROD_W'($signed(bus.data_i)) * PROD_W'(cfg_q.scale);
            s1_shift_d = cfg_q.shift;
            s1_zp_d    = cfg_q.zp;
        end
    end

    // Round half up: add half an LSB of the result, then floor-shift.
    always_comb begin
        prod_x   = RND_W'(s1_prod_q);
        rnd      = '0;
        s2_vld_d = s1_vld_q;
        s2_r_d   = s2_r_q;
        s2_zp_d  = s2_zp_q;
        if (s1_shift_q != '0) begin
            rnd = {{(RND_W-1){1'b0}}, 1'b1} << (s1_shift_q - SHIFT_W'(1));
        end
        if (s1_vld_q) begin
            s2_zp_d = s1_zp_q;
            if (s1_shift_q == '0) begin
                s2_r_d = prod_x;
            end else begin
                s2_r_d = (prod_x + rnd) >>> s1_shift_q;
            end
        end
    end

    assign sum = SUM_W'(s2_r_q) + SUM_W'(s2_zp_q);

    sat_clamp #(
        .IN_W  (SUM_W),
        .OUT_W (OUT_W)
    ) u_clamp (
        .x_i (sum),
        .y_o (sat)
    );

    always_comb begin
        out_vld_d = s2_vld_q;
        out_d     = out_q;
        if (s2_vld_q) begin
            out_d = sat;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cfg_q      <= REQ_CFG_RST;
            s1_vld_q   <= 1'b0;
            s1_prod_q  <= '0;
            s1_shift_q <= '0;
            s1_zp_q    <= '0;
            s2_vld_q   <= 1'b0;
            s2_r_q     <= '0;
            s2_zp_q    <= '0;
            out_vld_q  <= 1'b0;
            out_q      <= '0;
        end else begin
            cfg_q      <= cfg_d;
            s1_vld_q   <= s1_vld_d;
            s1_prod_q  <= s1_prod_d;
            s1_shift_q <= s1_shift_d;
            s1_zp_q    <= s1_zp_d;
            s2_vld_q   <= s2_vld_d;
            s2_r_q     <= s2_r_d;
            s2_zp_q    <= s2_zp_d;
            out_vld_q  <= out_vld_d;
            out_q      <= out_d;
        end
    end

    assign bus.data_valid_o = out_vld_q;
    assign bus.data_o       = out_q;

endmodule

// File: doc/requant.md
Name: requant

Overview:
- Downstream neighbour of the ReLU stage; consumes its 32-bit signed activation stream and requantizes each beat to a signed 8-bit value for writeback to the unified buffer.
- Fixed-point scale, then rounding right shift, then zero-point add, then saturate.
- 3-stage valid-only pipeline with no backpressure, matching the ReLU handshake.
- Runtime configuration (scale/shift/zero point) is loaded through a one-cycle config strobe.

Parameters:
- IN_W, 32, input data width (signed)
- SCALE_W, 32, multiplier width (signed)
- SHIFT_W, 6, shift amount width; legal shift 0..63
- OUT_W, 8, output width (signed, saturated)

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-high reset
- cfg_valid_i  in  1  load strobe for scale/shift/zero point
- cfg_scale_i  in  SCALE_W  signed multiplier
- cfg_shift_i  in  SHIFT_W  right-shift amount
- cfg_zp_i  in  OUT_W  signed output zero point
- data_valid_i  in  1  input beat valid
- data_i  in  IN_W  signed input, normally the ReLU output
- data_valid_o  out  1  output beat valid
- data_o  out  OUT_W  signed requantized output

Behaviour:
- Reset:
  - Clock is clk_i; reset rst_i is asynchronous, active-high.
  - Reset clears all pipeline valids, data_o, and data_valid_o to 0.
  - Active config resets to scale=1, shift=0, zp=0 (identity plus saturation).
- Config:
  - On a clk_i edge with cfg_valid_i=1, the active config registers capture the cfg_* inputs.
  - A beat accepted in the same cycle as cfg_valid_i uses the OLD config.
  - Beats accepted from the next cycle on use the new config.
  - Each stage carries its own copy of the config fields it still needs, so beats already in flight are unaffected by a config change.
- Stage 1 (multiply):
  - prod = data_i * scale, full width IN_W+SCALE_W (64) signed.
  - Register prod, shift, zp and valid.
- Stage 2 (round/shift):
  - If shift=0: r = prod.
  - Else: r = (prod + (1 << (shift-1))) >>> shift, arithmetic shift in 65-bit signed arithmetic so the add cannot overflow.
  - Rounding is round-half-up (toward +inf).
  - Register r, zp and valid.
- Stage 3 (offset/saturate):
  - s = r + sign-extended zp, computed with enough width to avoid wrap.
  - Clamp s to [-2^(OUT_W-1), 2^(OUT_W-1)-1] = [-128, 127].
  - Register into data_o and data_valid_o.
- Latency and throughput:
  - Exactly 3 cycles from data_valid_i sampled high to data_valid_o high.
  - Throughput 1 beat/cycle; back-to-back beats are never dropped or reordered.
- Bubbles:
  - When a stage's valid is 0, its data registers may hold stale values.
  - data_o updates only on cycles where data_valid_o is 1 and holds its last value otherwise.
- Reset mid-stream:
  - All in-flight beats are discarded; no valid is asserted after reset deasserts until new input arrives, 3 cycles later.
  - Config returns to identity.
- Shift handling: shift values 0..63 are all legal; there is no error flag.

Decomposition:
- Shared package tpu_pkg holds:
  - ACC_W=32, ACT_W=8, REQ_SHIFT_W=6.
  - typedef req_cfg_t: packed struct {scale, shift, zp}, used here and by the config/CSR block.
  - ACT_MAX=127 and ACT_MIN=-128 constants.
- One sub-module is natural: sat_clamp, parameterised by input width and OUT_W, purely combinational. Stage 3 instantiates it.

Test Plan:
- Reset identity:
  - After reset, data_i=50 -> data_o=50 three cycles later.
  - data_i=300 -> 127.
  - data_valid_o stays 0 during reset and for 3 cycles after.
- Scale/round:
  - cfg scale=32768, shift=16, zp=0; data_i=100 -> 50.
  - data_i=3, scale=1, shift=1 -> 2.
  - data_i=-3, scale=1, shift=1 -> -1 (half rounds up).
- Saturation:
  - scale=65536, shift=16; data_i=1000 -> 127.
  - data_i=-1000 -> -128.
  - data_i=0x7FFFFFFF with scale=0x7FFFFFFF, shift=0 -> 127 (no wrap).
- Zero point:
  - zp=-5, identity scale; data_i=0 -> -5.
  - zp=127, data_i=10 -> 127 (saturates).
- Config race:
  - Beat A (data 100) in the same cycle as cfg_valid_i setting shift=1; beat B (data 100) the next cycle.
  - A -> 100 (old identity config), B -> 50.
  - Outputs emerge on consecutive cycles.
- Streaming and reset:
  - 20 back-to-back beats with random bubbles -> outputs in order, 3-cycle latency, matching a reference model.
  - Assert rst_i with 2 beats in flight -> both dropped, data_valid_o=0, config back to identity.
